// File: rtl/gcd_pkg.sv
// Shared types and default sizing for the GCD job sequencer and its job FIFO.
package gcd_pkg;

   localparam int GCD_W       = 8;
   localparam int GCD_DEPTH   = 4;
   localparam int GCD_TIMEOUT = 300;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      LOAD_A = 3'd2,
      LOAD_B = 3'd3,
      WAIT   = 3'd4,
      RESP   = 3'd5
   } state_t;

   typedef struct packed {
      logic [GCD_W-1:0] a;
      logic [GCD_W-1:0] b;
   } job_t;

endpackage

// File: rtl/gcd_job_fifo.sv
// Show-ahead synchronous FIFO holding packed operand pairs waiting for the core.
module gcd_job_fifo
   import gcd_pkg::*;
#(
   parameter int DW    = 2 * GCD_W,
   parameter int DEPTH = GCD_DEPTH
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
   output logic [DW-1:0] o_head,
   output logic          o_full,
   output logic          o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic          w_do_push;
   logic          w_do_pop;

   // Extra pointer MSB separates full from empty when the index bits match.
   assign o_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
   assign o_empty   = (r_wptr == r_rptr);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_head    = r_mem[r_rptr[AW-1:0]];

   // Read/write pointer update.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr <= {PW{1'b0}};
         r_rptr <= {PW{1'b0}};
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
      end
   end

   // Storage write; contents need no reset since the pointers gate visibility.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wptr[AW-1:0]] <= i_data;
      end
   end

endmodule

// File: rtl/gcd_job_sequencer.sv
// Front-end that queues operand pairs, runs each through the subtraction GCD core
// (or bypasses it for zero operands) and returns results on a valid/ready stream.
module gcd_job_sequencer
   import gcd_pkg::*;
#(
   parameter int W       = GCD_W,
   parameter int DEPTH   = GCD_DEPTH,
   parameter int TIMEOUT = GCD_TIMEOUT
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [W-1:0] i_in_a,
   input  logic [W-1:0] i_in_b,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [W-1:0] o_out_gcd,
   output logic         o_out_err,
   output logic         o_core_rst,
   output logic         o_core_start,
   output logic [W-1:0] o_core_data,
   input  logic         i_core_done,
   input  logic [W-1:0] i_core_result
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t         r_state, w_state_nxt;
   logic [W-1:0]   r_ja, w_ja_nxt;
   logic [W-1:0]   r_jb, w_jb_nxt;
   logic [CW-1:0]  r_cnt, w_cnt_nxt;
   logic [W-1:0]   r_out_gcd, w_out_gcd_nxt;
   logic           r_out_err, w_out_err_nxt;
   logic           r_out_valid, r_core_start;
   logic [W-1:0]   r_core_data, w_core_data_nxt;
   logic           w_pop, w_push, w_full, w_empty;
   logic [2*W-1:0] w_head;
   logic [W-1:0]   w_head_a, w_head_b;

   assign o_in_ready = !w_full && !i_rst;
   assign w_push     = i_in_valid && o_in_ready;
   assign w_head_a   = w_head[2*W-1:W];
   assign w_head_b   = w_head[W-1:0];

   gcd_job_fifo #(.DW(2 * W), .DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_data  ({i_in_a, i_in_b}),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Next-state and next-register values for the job FSM.
   always_comb begin
      w_state_nxt   = r_state;
      w_ja_nxt      = r_ja;
      w_jb_nxt      = r_jb;
      w_cnt_nxt     = r_cnt;
      w_out_gcd_nxt = r_out_gcd;
      w_out_err_nxt = r_out_err;
      w_pop         = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop    = 1'b1;
               w_ja_nxt = w_head_a;
               w_jb_nxt = w_head_b;
               // A zero operand would spin the core forever; gcd(x,0) is x.
               if ((w_head_a == {W{1'b0}}) || (w_head_b == {W{1'b0}})) begin
                  w_state_nxt   = RESP;
                  w_out_gcd_nxt = w_head_a | w_head_b;
                  w_out_err_nxt = 1'b0;
               end else begin
                  w_state_nxt = CLEAR;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         CLEAR:  w_state_nxt = LOAD_A;
         LOAD_A: w_state_nxt = LOAD_B;
         LOAD_B: begin
            w_cnt_nxt   = {CW{1'b0}};
            w_state_nxt = WAIT;
         end
         WAIT: begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (i_core_done) begin
               w_out_gcd_nxt = i_core_result;
               w_out_err_nxt = 1'b0;
               w_state_nxt   = RESP;
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
               w_out_gcd_nxt = {W{1'b0}};
               w_out_err_nxt = 1'b1;
               w_state_nxt   = RESP;
            end else begin
               w_state_nxt = WAIT;
            end
         end
         RESP: begin
            if (i_out_ready) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = RESP;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Core bus value for the state being entered, so the bus is registered.
   always_comb begin
      case (w_state_nxt)
         LOAD_A:  w_core_data_nxt = w_ja_nxt;
         LOAD_B:  w_core_data_nxt = w_jb_nxt;
         default: w_core_data_nxt = {W{1'b0}};
      endcase
   end

   // State, job and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_ja         <= {W{1'b0}};
         r_jb         <= {W{1'b0}};
         r_cnt        <= {CW{1'b0}};
         r_out_gcd    <= {W{1'b0}};
         r_out_err    <= 1'b0;
         r_out_valid  <= 1'b0;
         r_core_start <= 1'b0;
         r_core_data  <= {W{1'b0}};
      end else begin
         r_state      <= w_state_nxt;
         r_ja         <= w_ja_nxt;
         r_jb         <= w_jb_nxt;
         r_cnt        <= w_cnt_nxt;
         r_out_gcd    <= w_out_gcd_nxt;
         r_out_err    <= w_out_err_nxt;
         r_out_valid  <= (w_state_nxt == RESP);
         r_core_start <= (w_state_nxt == LOAD_A);
         r_core_data  <= w_core_data_nxt;
      end
   end

   assign o_out_valid  = r_out_valid;
   assign o_out_gcd    = r_out_gcd;
   assign o_out_err    = r_out_err;
   assign o_core_start = r_core_start;
   assign o_core_data  = r_core_data;
   assign o_core_rst   = i_rst || (r_state == CLEAR);

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer with a behavioural subtraction-GCD core model.
module tb_gcd_job_sequencer;
   import gcd_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, out_err;
   logic [7:0] in_a, in_b, out_gcd, core_data, core_result;
   logic       core_rst, core_start, core_done;

   logic       force_en, force_done;
   logic [7:0] force_res;
   logic [7:0] m_a, m_b;
   logic [1:0] m_phase;
   logic       m_done;
   int         n_starts = 0;
   int         n_tests  = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   gcd_job_sequencer #(.W(8), .DEPTH(4), .TIMEOUT(300)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_a(in_a), .i_in_b(in_b),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_gcd(out_gcd), .o_out_err(out_err),
      .o_core_rst(core_rst), .o_core_start(core_start), .o_core_data(core_data),
      .i_core_done(core_done), .i_core_result(core_result)
   );

   // Core model: A on the start cycle, B on the next, then subtract until equal.
   always @(posedge clk) begin
      if (core_rst) begin
         m_phase <= 2'd0;
         m_done  <= 1'b0;
      end else if (core_start) begin
         m_a     <= core_data;
         m_phase <= 2'd1;
         m_done  <= 1'b0;
      end else if (m_phase == 2'd1) begin
         m_b     <= core_data;
         m_phase <= 2'd2;
      end else if (m_phase == 2'd2 && !m_done) begin
         if (m_a == m_b) m_done <= 1'b1;
         else if (m_a > m_b) m_a <= m_a - m_b;
         else m_b <= m_b - m_a;
      end
   end

   assign core_done   = force_en ? force_done : m_done;
   assign core_result = force_en ? force_res  : m_a;

   always @(posedge clk) begin
      if (core_start) n_starts <= n_starts + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input job_t j);
      int n = 0;
      @(negedge clk);
      in_a = j.a; in_b = j.b; in_valid = 1'b1;
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("push_ready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic get_result(input string tag, input logic [7:0] g, input logic e);
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_gcd"}, out_gcd, g);
      check({tag, "_err"}, out_err, e);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_drop"}, out_valid, 0);
   endtask

   task automatic wait_start(input string tag, output logic prev_rst);
      int n = 0;
      prev_rst = 1'b0;
      @(negedge clk);
      while (!core_start && n < 50) begin
         prev_rst = core_rst;
         @(negedge clk);
         n++;
      end
      check({tag, "_start"}, core_start, 1);
   endtask

   initial begin
      logic pr;
      int   n, s0;
      rst = 1'b1; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; out_ready = 1'b0;
      force_en = 1'b0; force_done = 1'b0; force_res = 8'd0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_core_rst", core_rst, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_gcd", out_gcd, 0);
      check("rst_out_err", out_err, 0);
      check("rst_core_start", core_start, 0);
      check("rst_core_data", core_data, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_core_rst", core_rst, 0);

      // Core path with bus sequencing and output hold under backpressure.
      push('{a: 8'd48, b: 8'd18});
      wait_start("core", pr);
      check("core_clear_rst", pr, 1);
      check("core_load_a", core_data, 48);
      @(negedge clk);
      check("core_load_b_start", core_start, 0);
      check("core_load_b", core_data, 18);
      @(negedge clk);
      check("core_wait_data", core_data, 0);
      n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      check("core_hold_valid", out_valid, 1);
      check("core_hold_gcd", out_gcd, 6);
      get_result("core", 8'd6, 1'b0);

      // Zero-operand bypass: result one cycle after the pop, core untouched.
      s0 = n_starts;
      push('{a: 8'd0, b: 8'd7});
      @(negedge clk);
      check("byp7_pop_cycle", out_valid, 0);
      @(negedge clk);
      check("byp7_lat_valid", out_valid, 1);
      check("byp7_lat_gcd", out_gcd, 7);
      get_result("byp7", 8'd7, 1'b0);
      push('{a: 8'd0, b: 8'd0});
      @(negedge clk);
      @(negedge clk);
      check("byp0_lat_valid", out_valid, 1);
      get_result("byp0", 8'd0, 1'b0);
      check("byp_no_start", n_starts, s0);

      // Fill the FIFO behind a stalled result; in-order drain afterwards.
      push('{a: 8'd48, b: 8'd18});
      push('{a: 8'd7,  b: 8'd5});
      push('{a: 8'd13, b: 8'd13});
      push('{a: 8'd12, b: 8'd8});
      push('{a: 8'd0,  b: 8'd9});
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
      in_a = 8'd35; in_b = 8'd14; in_valid = 1'b1;
      repeat (10) @(negedge clk);
      check("full_refuse", in_ready, 0);
      in_valid = 1'b0;
      get_result("bp6", 8'd6, 1'b0);
      push('{a: 8'd35, b: 8'd14});
      get_result("bp1", 8'd1, 1'b0);
      get_result("bp13", 8'd13, 1'b0);
      get_result("bp4", 8'd4, 1'b0);
      get_result("bp9", 8'd9, 1'b0);
      get_result("bp7", 8'd7, 1'b0);

      // Timeout with a hung core, then a normal job.
      force_en = 1'b1; force_done = 1'b0; force_res = 8'd77;
      push('{a: 8'd9, b: 8'd6});
      wait_start("tmo", pr);
      @(negedge clk);
      @(negedge clk);
      n = 0;
      while (!out_valid && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("tmo_cycles", n, 300);
      get_result("tmo", 8'd0, 1'b1);
      force_en = 1'b0;
      push('{a: 8'd27, b: 8'd18});
      get_result("after_tmo", 8'd9, 1'b0);

      // Done arriving on the last allowed WAIT cycle beats the timeout.
      force_en = 1'b1; force_done = 1'b0; force_res = 8'd55;
      push('{a: 8'd9, b: 8'd6});
      wait_start("sim", pr);
      @(negedge clk);
      @(negedge clk);
      repeat (298) @(negedge clk);
      check("sim_not_early", out_valid, 0);
      @(negedge clk);
      force_done = 1'b1;
      @(negedge clk);
      check("sim_valid", out_valid, 1);
      get_result("sim", 8'd55, 1'b0);
      force_done = 1'b0; force_en = 1'b0;

      // Reset with one job in WAIT and two queued: everything is discarded.
      force_en = 1'b1;
      push('{a: 8'd9,  b: 8'd6});
      push('{a: 8'd10, b: 8'd4});
      push('{a: 8'd8,  b: 8'd2});
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_core_rst", core_rst, 1);
      check("mid_rst_in_ready", in_ready, 0);
      rst = 1'b0;
      force_en = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready_after", in_ready, 1);
      s0 = n_starts;
      repeat (20) @(negedge clk);
      check("mid_rst_no_output", out_valid, 0);
      check("mid_rst_fifo_empty", n_starts, s0);
      push('{a: 8'd21, b: 8'd14});
      get_result("post_rst", 8'd7, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
